// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble controller for the 5-stage pipeline: Tuse/Tnew data hazards, mult/div busy
// sequencing, a saturating stall-cycle counter and a sticky protocol-error flag.
module pipe_hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic [1:0]       tuse_rs_d,
    input  logic [1:0]       tuse_rt_d,
    input  logic [4:0]       a3_e,
    input  logic [1:0]       tnew_e,
    input  logic [4:0]       a3_m,
    input  logic [1:0]       tnew_m,
    input  logic             md_d,
    input  logic             md_start_e,
    input  logic             md_div_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             md_busy,
    output logic [CNT_W-1:0] md_cnt,
    output logic [31:0]      stall_cycles,
    output logic             proto_err
);

    localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES);

    logic             hz_e;
    logic             hz_m;
    logic             hz_md;
    logic             stall;
    logic [CNT_W-1:0] md_cnt_d,       md_cnt_q;
    logic             md_busy_q;
    logic [31:0]      stall_cycles_d, stall_cycles_q;
    logic             proto_err_d,    proto_err_q;

    // A stall is needed only when the producer's result arrives later than the consumer needs it.
    assign hz_e = (a3_e != 5'd0) &&
                  (((rs_d == a3_e) && (tuse_rs_d < tnew_e)) ||
                   ((rt_d == a3_e) && (tuse_rt_d < tnew_e)));
    assign hz_m = (a3_m != 5'd0) &&
                  (((rs_d == a3_m) && (tuse_rs_d < tnew_m)) ||
                   ((rt_d == a3_m) && (tuse_rt_d < tnew_m)));
    assign hz_md = md_d && (md_busy_q || md_start_e);
    assign stall = hz_e || hz_m || hz_md;

    always_comb begin
        md_cnt_d       = md_cnt_q;
        stall_cycles_d = stall_cycles_q;
        proto_err_d    = proto_err_q | (md_start_e & md_busy_q);
        if (md_start_e) begin
            md_cnt_d = md_div_e ? DivLoad : MultLoad;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_q       <= '0;
            md_busy_q      <= 1'b0;
            stall_cycles_q <= 32'd0;
            proto_err_q    <= 1'b0;
        end else begin
            md_cnt_q       <= md_cnt_d;
            md_busy_q      <= (md_cnt_d != '0);
            stall_cycles_q <= stall_cycles_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign stall_f      = stall;
    assign stall_d      = stall;
    assign flush_e      = stall;
    assign md_busy      = md_busy_q;
    assign md_cnt       = md_cnt_q;
    assign stall_cycles = stall_cycles_q;
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a reference model pushes expected outputs each cycle.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  rs_d = '0, rt_d = '0, a3_e = '0, a3_m = '0;
    logic [1:0]  tuse_rs_d = 2'd3, tuse_rt_d = 2'd3, tnew_e = '0, tnew_m = '0;
    logic        md_d = 1'b0, md_start_e = 1'b0, md_div_e = 1'b0;
    logic        stall_f, stall_d, flush_e, md_busy, proto_err;
    logic [3:0]  md_cnt;
    logic [31:0] stall_cycles;

    pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d),
        .tuse_rt_d(tuse_rt_d), .a3_e(a3_e), .tnew_e(tnew_e), .a3_m(a3_m), .tnew_m(tnew_m),
        .md_d(md_d), .md_start_e(md_start_e), .md_div_e(md_div_e), .stall_f(stall_f),
        .stall_d(stall_d), .flush_e(flush_e), .md_busy(md_busy), .md_cnt(md_cnt),
        .stall_cycles(stall_cycles), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        stall;
        logic        busy;
        logic [3:0]  cnt;
        logic [31:0] sc;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // Reference model state
    logic [3:0]  m_cnt = '0;
    logic [31:0] m_sc = '0;
    logic        m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic hz(input logic [4:0] a3, input logic [1:0] tn);
        return (a3 != 0) && (((rs_d == a3) && (tuse_rs_d < tn)) || ((rt_d == a3) && (tuse_rt_d < tn)));
    endfunction

    // Entered just after a falling edge; leaves just after the next falling edge.
    task automatic step(input string tag, input logic [4:0] rs, input logic [1:0] tur,
                        input logic [4:0] rt, input logic [1:0] tut,
                        input logic [4:0] ae, input logic [1:0] tne,
                        input logic [4:0] am, input logic [1:0] tnm,
                        input logic mdd, input logic st, input logic dv);
        exp_t e;
        logic s;
        logic [3:0] ncnt;
        rs_d = rs; tuse_rs_d = tur; rt_d = rt; tuse_rt_d = tut;
        a3_e = ae; tnew_e = tne; a3_m = am; tnew_m = tnm;
        md_d = mdd; md_start_e = st; md_div_e = dv;
        s = hz(ae, tne) || hz(am, tnm) || (mdd && ((m_cnt != 0) || st));
        e.tag = tag; e.stall = s; e.busy = (m_cnt != 0); e.cnt = m_cnt; e.sc = m_sc; e.err = m_err;
        exp_q.push_back(e);
        #1;
        e = exp_q.pop_front();
        check({e.tag, ".stall_f"}, 32'(stall_f), 32'(e.stall));
        check({e.tag, ".stall_d"}, 32'(stall_d), 32'(e.stall));
        check({e.tag, ".flush_e"}, 32'(flush_e), 32'(e.stall));
        check({e.tag, ".md_busy"}, 32'(md_busy), 32'(e.busy));
        check({e.tag, ".md_cnt"}, 32'(md_cnt), 32'(e.cnt));
        check({e.tag, ".stall_cycles"}, stall_cycles, e.sc);
        check({e.tag, ".proto_err"}, 32'(proto_err), 32'(e.err));
        ncnt = st ? (dv ? 4'd10 : 4'd5) : ((m_cnt != 0) ? m_cnt - 4'd1 : 4'd0);
        if (st && (m_cnt != 0)) m_err = 1'b1;
        if (s && (m_sc != 32'hFFFF_FFFF)) m_sc = m_sc + 1;
        m_cnt = ncnt;
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input logic mdd);
        step(tag, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, mdd, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        m_cnt = '0; m_sc = '0; m_err = 1'b0;
        check({tag, ".md_cnt"}, 32'(md_cnt), 32'd0);
        check({tag, ".md_busy"}, 32'(md_busy), 32'd0);
        check({tag, ".stall_cycles"}, stall_cycles, 32'd0);
        check({tag, ".proto_err"}, 32'(proto_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] base;
        int guard;
        @(negedge clk);
        do_reset("reset");
        idle("idle0", 1'b0);

        // Load-use on E, then the same producer one stage later in M
        step("lw_use", 5'd1, 2'd1, 5'd3, 2'd1, 5'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        step("lw_m", 5'd1, 2'd1, 5'd3, 2'd1, 5'd0, 2'd0, 5'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        check("lw_stall_count", stall_cycles, 32'd1);

        // $0 never stalls; rt with tuse=3 never stalls
        for (int i = 0; i < 3; i++)
            step("zero_reg", 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd2, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        step("tuse3", 5'd4, 2'd3, 5'd4, 2'd3, 5'd4, 2'd2, 5'd4, 2'd2, 1'b0, 1'b0, 1'b0);
        step("rt_hz_m", 5'd0, 2'd3, 5'd7, 2'd0, 5'd0, 2'd0, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);

        // mult with mflo waiting in D
        base = stall_cycles;
        step("mult_start", 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        guard = 0;
        while (m_cnt != 0 && guard < 20) begin
            idle("mult_wait", 1'b1);
            guard++;
        end
        check("mult_wait_bound", 32'(guard), 32'd5);
        idle("mult_release", 1'b1);
        check("mult_stall_count", stall_cycles - base, 32'd6);

        // Simultaneous E hazard and MD hazard count once
        base = stall_cycles;
        step("md_start_dual", 5'd2, 2'd0, 5'd0, 2'd3, 5'd2, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        check("dual_once", stall_cycles - base, 32'd1);
        for (int i = 0; i < 5; i++) idle("drain", 1'b0);

        // div, then asynchronous reset at md_cnt=4
        step("div_start", 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1);
        guard = 0;
        while (m_cnt != 4 && guard < 20) begin
            idle("div_wait", 1'b0);
            guard++;
        end
        check("div_wait_bound", 32'(guard), 32'd6);
        do_reset("reset_mid_div");
        idle("post_reset", 1'b0);

        // Second mult start while busy
        step("mult_a", 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        idle("mult_a_w", 1'b0);
        idle("mult_a_w", 1'b0);
        step("mult_b", 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        check("reload_cnt", 32'(md_cnt), 32'd5);
        for (int i = 0; i < 8; i++) idle("err_sticky", 1'b0);
        check("err_persist", 32'(proto_err), 32'd1);
        do_reset("reset_err");

        // Saturation of the perf counter
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_q;
        m_sc = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++)
            step("sat", 5'd9, 2'd0, 5'd0, 2'd3, 5'd9, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("sat_final", stall_cycles, 32'hFFFF_FFFF);
        idle("sat_hold", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
